fp_to_fixed_pipe: RTL and testbench



---
 rtl/fp_to_fixed_pipe.sv | 151 +++++++++++++++
 tb/tb_fp_to_fixed_pipe.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fp_to_fixed_pipe.sv
// fp_to_fixed_pipe: converts IEEE-754 single-precision operands to signed
// fixed point (1 sign + INT_W integer + FRAC_W fraction bits) in a 3-stage
// pipeline with a valid/ready handshake on both sides.
//   S1 unpack/classify, S2 align shift (guard + sticky), S3 round/negate/saturate.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready/fp_i   - operand handshake and operand
//   out_valid/out_ready      - result handshake
//   fixed_o                  - two's-complement result, LSB = 2^-FRAC_W
//   ovf_o/nan_o/inexact_o    - saturated / NaN operand / bits discarded
// The whole pipe advances together; it stalls only when the output register
// holds a result the consumer has not taken.
module fp_to_fixed_pipe #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 23,
  parameter int ROUND  = 1,
  localparam int OUT_W = 1 + INT_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      fp_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] fixed_o,
  output logic             ovf_o,
  output logic             nan_o,
  output logic             inexact_o
);
  localparam int STAGES = 3;
  // Magnitude width: largest in-range left shift (OUT_W-1) of a 24-bit
  // significand plus headroom so the rounding increment never wraps.
  localparam int WW = OUT_W + 25;
  // Scaled value = M * 2^(E - 150 + FRAC_W); this is the constant part.
  localparam logic signed [15:0] SH_ADJ = 16'(FRAC_W - 150);
  localparam logic [WW-1:0] POS_LIM = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [WW-1:0] NEG_LIM = POS_LIM + 1'b1;

  typedef struct packed {
    logic               sign;
    logic               nan;
    logic               inf;
    logic [23:0]        man;
    logic signed [15:0] sh;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic          nan;
    logic          big;
    logic [WW-1:0] mag;
    logic          guard;
    logic          sticky;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            adv;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  // Reset clears the output register, so ready is forced high while it is held.
  assign in_ready  = adv || rst;

  // S1: unpack. Denormals/zero use exponent 1 with no hidden bit.
  logic [7:0] e_raw;
  assign e_raw = fp_i[30:23];
  always_comb begin
    s1_d      = '0;
    s1_d.sign = fp_i[31];
    s1_d.nan  = (e_raw == 8'hFF) && (fp_i[22:0] != '0);
    s1_d.inf  = (e_raw == 8'hFF) && (fp_i[22:0] == '0);
    s1_d.man  = {e_raw != 8'd0, fp_i[22:0]};
    s1_d.sh   = $signed({8'd0, (e_raw == 8'd0) ? 8'd1 : e_raw}) + SH_ADJ;
  end

  // S2: align. Right shifts of 26+ leave nothing but sticky, so the count
  // is clamped rather than allowed to wrap.
  logic [15:0] rs;
  logic [49:0] rsh;
  assign rs = 16'(-s1_q.sh);
  always_comb begin
    s2_d      = '0;
    rsh       = '0;
    s2_d.sign = s1_q.sign;
    s2_d.nan  = s1_q.nan;
    s2_d.big  = s1_q.inf;
    if (!s1_q.sh[15]) begin
      if (s1_q.sh >= 16'(OUT_W))
        s2_d.big = s2_d.big || (s1_q.man != '0);
      else
        s2_d.mag = WW'(s1_q.man) << s1_q.sh;
    end else if (rs >= 16'd26) begin
      s2_d.sticky = |s1_q.man;
    end else begin
      rsh         = {s1_q.man, 26'd0} >> rs;
      s2_d.mag    = WW'(rsh[49:26]);
      s2_d.guard  = rsh[25];
      s2_d.sticky = |rsh[24:0];
    end
  end

  // S3: round magnitude, then saturate, then apply sign.
  logic             inc;
  logic [WW-1:0]    rnd;
  logic [OUT_W-1:0] fixed_d;
  logic             ovf_d, nan_d, inx_d;
  always_comb begin
    inc     = (ROUND != 0) && s2_q.guard && (s2_q.sticky || s2_q.mag[0]);
    rnd     = s2_q.mag + WW'(inc);
    fixed_d = '0;
    ovf_d   = 1'b0;
    nan_d   = 1'b0;
    inx_d   = 1'b0;
    if (s2_q.nan) begin
      nan_d = 1'b1;
    end else if (s2_q.big || (s2_q.sign ? (rnd > NEG_LIM) : (rnd > POS_LIM))) begin
      ovf_d   = 1'b1;
      fixed_d = s2_q.sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      fixed_d = s2_q.sign ? -rnd[OUT_W-1:0] : rnd[OUT_W-1:0];
      inx_d   = s2_q.guard || s2_q.sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      fixed_o   <= '0;
      ovf_o     <= 1'b0;
      nan_o     <= 1'b0;
      inexact_o <= 1'b0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      fixed_o   <= fixed_d;
      ovf_o     <= ovf_d;
      nan_o     <= nan_d;
      inexact_o <= inx_d;
    end
  end

  // Datapath registers carry no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
module tb_fp_to_fixed_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] fp_i;
  logic        ir, ov, ovf, nan, inx;
  logic [31:0] fx;
  logic        ir_t, ov_t, ovf_t, nan_t, inx_t;
  logic [31:0] fx_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_to_fixed_pipe #(.INT_W(8), .FRAC_W(23), .ROUND(1)) u_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir), .fp_i(fp_i),
    .out_valid(ov), .out_ready(out_ready), .fixed_o(fx), .ovf_o(ovf),
    .nan_o(nan), .inexact_o(inx));

  fp_to_fixed_pipe #(.INT_W(8), .FRAC_W(23), .ROUND(0)) u_trn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_t), .fp_i(fp_i),
    .out_valid(ov_t), .out_ready(out_ready), .fixed_o(fx_t), .ovf_o(ovf_t),
    .nan_o(nan_t), .inexact_o(inx_t));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] fp;
    logic [31:0] rne;
    logic [31:0] trn;
    logic        ovf, nan, inx;
  } vec_t;

  vec_t vt[16];
  logic [31:0] stim[5];
  logic [31:0] sexp[5];

  initial begin
    int acc, got, first_cyc, last_cyc;
    logic hs_in;

    vt[0]  = '{32'h3F800000, 32'h00800000, 32'h00800000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'hC0200000, 32'hFEC00000, 32'hFEC00000, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{32'h447A0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{32'hFF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{32'h7FC00000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{32'h33C00000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{32'h33800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{32'h43800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[10] = '{32'hC3800000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h43000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vt[12] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[13] = '{32'hB4400000, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vt[14] = '{32'h3EAAAAAB, 32'h002AAAAB, 32'h002AAAAA, 1'b0, 1'b0, 1'b1};
    vt[15] = '{32'hFFC00001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};

    stim = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    sexp = '{32'h00800000, 32'h01000000, 32'h01800000, 32'h02000000, 32'h02800000};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fp_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_fixed", fx, 32'd0);
    chk("rst_flags", {29'd0, ovf, nan, inx}, 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd1);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Directed vectors: one sample at a time, exact 3-cycle latency
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; fp_i = vt[i].fp;
      @(negedge clk);
      in_valid = 1'b0; fp_i = '0;
      @(negedge clk);
      chk($sformatf("v%0d_early_valid", i), 32'(ov), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(ov), 32'd1);
      chk($sformatf("v%0d_fixed_rne", i), fx, vt[i].rne);
      chk($sformatf("v%0d_fixed_trn", i), fx_t, vt[i].trn);
      chk($sformatf("v%0d_flags", i), {29'd0, ovf, nan, inx}, {29'd0, vt[i].ovf, vt[i].nan, vt[i].inx});
      chk($sformatf("v%0d_inx_trn", i), 32'(inx_t), 32'(vt[i].inx));
    end
    @(negedge clk);
    chk("drain_valid", 32'(ov), 32'd0);

    // Back-pressure: 5 samples offered against a blocked consumer
    acc = 0; got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = (acc < 5);
      fp_i      = (acc < 5) ? stim[acc] : 32'd0;
      out_ready = (cyc >= 6);
      #1;
      if (cyc == 5) begin
        chk("stall_accepted", 32'(acc), 32'd3);
        chk("stall_in_ready", 32'(ir), 32'd0);
        chk("stall_hold_fixed", fx, sexp[0]);
        chk("stall_hold_valid", 32'(ov), 32'd1);
      end
      if (ov && out_ready) begin
        if (got < 5) chk($sformatf("stall_out%0d", got), fx, sexp[got]);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      hs_in = in_valid && ir;
      @(posedge clk);
      if (hs_in) acc++;
      @(negedge clk);
    end
    chk("stall_count", 32'(got), 32'd5);
    chk("stall_back_to_back", 32'(last_cyc - first_cyc), 32'd4);

    // Reset with two samples in flight, and a sample offered during reset
    in_valid = 1'b1; out_ready = 1'b1; fp_i = 32'h3F800000;
    @(negedge clk);
    fp_i = 32'h40000000;
    @(negedge clk);
    fp_i = 32'h40400000; rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov), 32'd0);
    chk("midrst_in_ready", 32'(ir), 32'd1);
    chk("midrst_fixed", fx, 32'd0);
    rst = 1'b0; in_valid = 1'b0; fp_i = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_stale%0d", k), 32'(ov), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
